// File: rtl/if_id_reg.sv
// Fetch/decode pipeline register: stall, flush, exception bubble,
// fetch AdEL tagging (define FETCH_ADEL_EN) and accepted-instruction count.
module if_id_reg #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] IM_LO      = 32'h0000_3000,
  parameter logic [31:0] IM_HI      = 32'h0000_4ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        flush,
  input  logic        Req,
  input  logic [31:0] F_Instr,
  input  logic [31:0] F_PC,
  input  logic        F_isBD,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [4:0]  D_ExcCode,
  output logic        D_isBD,
  output logic        D_valid,
  output logic [31:0] fetch_cnt
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] cnt_d, cnt_q;
  logic [4:0]  exc_d, exc_q;
  logic        bd_d, bd_q;
  logic        valid_d, valid_q;
  logic        adel;

`ifdef FETCH_ADEL_EN
  // Misaligned or outside instruction memory window (unsigned compare)
  assign adel = (F_PC[1:0] != 2'b00)
             || (F_PC < IM_LO)
             || (F_PC > IM_HI);
`else
  // Window bounds are only meaningful with address checking built in
  logic unused_cfg;
  assign unused_cfg = ^{IM_LO, IM_HI};
  assign adel = 1'b0;
`endif

  // Next-state: reset > Req > stall hold > flush bubble > load
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (reset) begin
      instr_d = '0;
      pc_d    = RESET_PC;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (Req) begin
      instr_d = '0;
      pc_d    = HANDLER_PC;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else if (!EN) begin
      instr_d = instr_q;
    end else if (flush) begin
      instr_d = '0;
      pc_d    = F_PC;
      exc_d   = EXC_NONE;
      bd_d    = 1'b0;
      valid_d = 1'b0;
    end else begin
      pc_d    = F_PC;
      bd_d    = F_isBD;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
      if (adel) begin
        instr_d = '0;
        exc_d   = EXC_ADEL;
      end else begin
        instr_d = F_Instr;
        exc_d   = EXC_NONE;
      end
    end
  end

  // State registers; all outputs come straight from flops
  always_ff @(posedge clk) begin
    instr_q <= instr_d;
    pc_q    <= pc_d;
    exc_q   <= exc_d;
    bd_q    <= bd_d;
    valid_q <= valid_d;
    cnt_q   <= cnt_d;
  end

  assign D_Instr   = instr_q;
  assign D_PC      = pc_q;
  assign D_ExcCode = exc_q;
  assign D_isBD    = bd_q;
  assign D_valid   = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg.
// Covers reset, load, stall, AdEL, Req, flush, wrap, back-to-back.
module tb_if_id_reg;

  logic        clk = 1'b0;
  logic        reset, EN, flush, Req, F_isBD;
  logic [31:0] F_Instr, F_PC;
  logic [31:0] D_Instr, D_PC, fetch_cnt;
  logic [4:0]  D_ExcCode;
  logic        D_isBD, D_valid;

  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] exp_cnt;

  if_id_reg dut (
    .clk(clk), .reset(reset), .EN(EN), .flush(flush), .Req(Req),
    .F_Instr(F_Instr), .F_PC(F_PC), .F_isBD(F_isBD),
    .D_Instr(D_Instr), .D_PC(D_PC), .D_ExcCode(D_ExcCode),
    .D_isBD(D_isBD), .D_valid(D_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; EN = 0; flush = 0; Req = 0;
    F_Instr = 32'h1111_1111; F_PC = 32'h0000_3abc; F_isBD = 1;
    step();
    n_chk++; if (D_Instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want %h", D_Instr, 32'h0); end
    n_chk++; if (D_PC !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got %h want %h", D_PC, 32'h3000); end
    n_chk++; if (D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL reset_exc got %0d want 0", D_ExcCode); end
    n_chk++; if (D_isBD !== 1'b0) begin n_fail++; $display("FAIL reset_bd got %b want 0", D_isBD); end
    n_chk++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", D_valid); end
    n_chk++; if (fetch_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", fetch_cnt); end
    exp_cnt = 0;
  endtask

  task automatic test_load();
    reset = 0; EN = 1;
    F_Instr = 32'h3c01_1234; F_PC = 32'h0000_3000; F_isBD = 0;
    step();
    exp_cnt = 1;
    n_chk++; if (D_Instr !== 32'h3c01_1234) begin n_fail++; $display("FAIL load_instr got %h want %h", D_Instr, 32'h3c011234); end
    n_chk++; if (D_PC !== 32'h3000) begin n_fail++; $display("FAIL load_pc got %h want %h", D_PC, 32'h3000); end
    n_chk++; if (D_valid !== 1'b1) begin n_fail++; $display("FAIL load_valid got %b want 1", D_valid); end
    n_chk++; if (D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL load_exc got %0d want 0", D_ExcCode); end
    n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL load_cnt got %h want %h", fetch_cnt, exp_cnt); end
  endtask

  task automatic test_stall();
    EN = 0;
    for (int i = 0; i < 3; i++) begin
      F_Instr = 32'hab00_0000 + i; F_PC = 32'h3100 + 4 * i; F_isBD = 1;
      step();
      n_chk++; if (D_Instr !== 32'h3c01_1234) begin n_fail++; $display("FAIL stall_instr got %h want %h", D_Instr, 32'h3c011234); end
      n_chk++; if (D_PC !== 32'h3000) begin n_fail++; $display("FAIL stall_pc got %h want %h", D_PC, 32'h3000); end
      n_chk++; if (D_isBD !== 1'b0) begin n_fail++; $display("FAIL stall_bd got %b want 0", D_isBD); end
      n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL stall_cnt got %h want %h", fetch_cnt, exp_cnt); end
    end
    EN = 1; F_Instr = 32'h2421_0001; F_PC = 32'h3004; F_isBD = 1;
    step();
    exp_cnt++;
    n_chk++; if (D_Instr !== 32'h2421_0001) begin n_fail++; $display("FAIL resume_instr got %h want %h", D_Instr, 32'h24210001); end
    n_chk++; if (D_PC !== 32'h3004) begin n_fail++; $display("FAIL resume_pc got %h want %h", D_PC, 32'h3004); end
    n_chk++; if (D_isBD !== 1'b1) begin n_fail++; $display("FAIL resume_bd got %b want 1", D_isBD); end
    n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL resume_cnt got %h want %h", fetch_cnt, exp_cnt); end
  endtask

  task automatic test_adel();
    logic [31:0] pcs [4];
    logic        bad [4];
    logic [31:0] ei;
    logic [4:0]  ee;
    pcs[0] = 32'h3002; bad[0] = 1;
    pcs[1] = 32'h5000; bad[1] = 1;
    pcs[2] = 32'h4ffc; bad[2] = 0;
    pcs[3] = 32'h2ffc; bad[3] = 1;
    for (int i = 0; i < 4; i++) begin
      EN = 1; F_PC = pcs[i]; F_Instr = 32'hdead_be00 + i; F_isBD = 1;
      step();
      exp_cnt++;
`ifdef FETCH_ADEL_EN
      ei = bad[i] ? 32'h0 : F_Instr;
      ee = bad[i] ? 5'd4 : 5'd0;
`else
      ei = F_Instr;
      ee = 5'd0;
`endif
      n_chk++; if (D_ExcCode !== ee) begin n_fail++; $display("FAIL adel_exc pc=%h got %0d want %0d", pcs[i], D_ExcCode, ee); end
      n_chk++; if (D_Instr !== ei) begin n_fail++; $display("FAIL adel_instr pc=%h got %h want %h", pcs[i], D_Instr, ei); end
      n_chk++; if (D_PC !== pcs[i]) begin n_fail++; $display("FAIL adel_pc got %h want %h", D_PC, pcs[i]); end
      n_chk++; if (D_isBD !== 1'b1) begin n_fail++; $display("FAIL adel_bd got %b want 1", D_isBD); end
      n_chk++; if (D_valid !== 1'b1) begin n_fail++; $display("FAIL adel_valid got %b want 1", D_valid); end
      n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL adel_cnt got %h want %h", fetch_cnt, exp_cnt); end
    end
  endtask

  task automatic test_req();
    Req = 1; EN = 0; flush = 1; F_PC = 32'h3040; F_isBD = 1; F_Instr = 32'h1234_5678;
    step();
    Req = 0;
    n_chk++; if (D_PC !== 32'h4180) begin n_fail++; $display("FAIL req_pc got %h want %h", D_PC, 32'h4180); end
    n_chk++; if (D_Instr !== 32'h0) begin n_fail++; $display("FAIL req_instr got %h want 0", D_Instr); end
    n_chk++; if (D_isBD !== 1'b0) begin n_fail++; $display("FAIL req_bd got %b want 0", D_isBD); end
    n_chk++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL req_valid got %b want 0", D_valid); end
    n_chk++; if (D_ExcCode !== 5'd0) begin n_fail++; $display("FAIL req_exc got %0d want 0", D_ExcCode); end
    n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL req_cnt got %h want %h", fetch_cnt, exp_cnt); end
  endtask

  task automatic test_flush();
    flush = 1; EN = 1; F_PC = 32'h3010; F_isBD = 1; F_Instr = 32'h8c22_0004;
    step();
    n_chk++; if (D_Instr !== 32'h0) begin n_fail++; $display("FAIL flush_instr got %h want 0", D_Instr); end
    n_chk++; if (D_PC !== 32'h3010) begin n_fail++; $display("FAIL flush_pc got %h want %h", D_PC, 32'h3010); end
    n_chk++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", D_valid); end
    n_chk++; if (D_isBD !== 1'b0) begin n_fail++; $display("FAIL flush_bd got %b want 0", D_isBD); end
    n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt got %h want %h", fetch_cnt, exp_cnt); end
    EN = 0; F_PC = 32'h3020;
    step();
    n_chk++; if (D_PC !== 32'h3010) begin n_fail++; $display("FAIL stallflush_pc got %h want %h", D_PC, 32'h3010); end
    n_chk++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL stallflush_valid got %b want 0", D_valid); end
    flush = 0;
  endtask

  task automatic test_wrap();
    dut.cnt_q = 32'hffff_ffff;
    EN = 1; flush = 0; F_PC = 32'h3008; F_Instr = 32'h0000_0021; F_isBD = 0;
    step();
    n_chk++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL wrap_cnt got %h want 0", fetch_cnt); end
    n_chk++; if (D_valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid got %b want 1", D_valid); end
    exp_cnt = 0;
  endtask

  task automatic test_back_to_back();
    EN = 1; flush = 0; Req = 0;
    for (int i = 0; i < 4; i++) begin
      F_PC = 32'h3200 + 4 * i; F_Instr = 32'h2000_0000 + i; F_isBD = i[0];
      step();
      exp_cnt++;
      n_chk++; if (D_Instr !== 32'h2000_0000 + i) begin n_fail++; $display("FAIL b2b_instr got %h want %h", D_Instr, 32'h20000000 + i); end
      n_chk++; if (D_PC !== 32'h3200 + 4 * i) begin n_fail++; $display("FAIL b2b_pc got %h want %h", D_PC, 32'h3200 + 4 * i); end
      n_chk++; if (D_isBD !== i[0]) begin n_fail++; $display("FAIL b2b_bd got %b want %b", D_isBD, i[0]); end
      n_chk++; if (fetch_cnt !== exp_cnt) begin n_fail++; $display("FAIL b2b_cnt got %h want %h", fetch_cnt, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid();
    EN = 0; flush = 1; reset = 1; F_PC = 32'h3300;
    step();
    reset = 0; flush = 0;
    n_chk++; if (D_PC !== 32'h3000) begin n_fail++; $display("FAIL rstmid_pc got %h want %h", D_PC, 32'h3000); end
    n_chk++; if (D_Instr !== 32'h0) begin n_fail++; $display("FAIL rstmid_instr got %h want 0", D_Instr); end
    n_chk++; if (D_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b want 0", D_valid); end
    n_chk++; if (D_isBD !== 1'b0) begin n_fail++; $display("FAIL rstmid_bd got %b want 0", D_isBD); end
    n_chk++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL rstmid_cnt got %h want 0", fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_adel();
    test_req();
    test_flush();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
